// File: rtl/pmp_join16_resolver.sv
// 16-way join of per-entry PMP comparator results with lowest-index priority
// resolution; presents an allow/fault verdict over valid/ready and frees upstream.
module pmp_join16_resolver #(
  parameter int N_ENTRY = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_ENTRY-1:0] i_drive,
  input  logic [N_ENTRY-1:0] i_match,
  input  logic [N_ENTRY-1:0] i_perm_ok,
  input  logic [N_ENTRY-1:0] i_locked,
  input  logic               i_priv_m,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_fault,
  output logic               o_hit,
  output logic [3:0]         o_hit_idx,
  output logic               o_free,
  output logic               o_proto_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, HOLD} state_t;

  state_t             state, state_nxt;
  logic [N_ENTRY-1:0] arrived, arrived_nxt, fresh, dup;
  logic [N_ENTRY-1:0] match_q, perm_q, lock_q;
  logic               priv_q;
  logic               capture, err, handshake;
  logic               found;
  logic [3:0]         idx;
  logic               fault_c;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    fresh       = i_drive & ~arrived;
    dup         = i_drive & arrived;
    arrived_nxt = arrived | fresh;
    state_nxt   = state;
    capture     = 1'b0;
    err         = 1'b0;
    handshake   = 1'b0;
    case (state)
      IDLE: begin
        if (|i_drive) begin
          capture   = 1'b1;
          state_nxt = (arrived_nxt == '1) ? RESOLVE : COLLECT;
        end
      end
      COLLECT: begin
        capture = 1'b1;
        err     = |dup;
        if (arrived_nxt == '1) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        err       = |i_drive;
        state_nxt = HOLD;
      end
      HOLD: begin
        err = |i_drive;
        if (i_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lowest matching index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_ENTRY; i++) begin
      if (match_q[i] && !found) begin
        found = 1'b1;
        idx   = 4'(i);
      end
    end
    fault_c = found ? (~perm_q[idx] & (~priv_q | lock_q[idx])) : ~priv_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      arrived     <= '0;
      match_q     <= '0;
      perm_q      <= '0;
      lock_q      <= '0;
      priv_q      <= 1'b0;
      o_fault     <= 1'b0;
      o_hit       <= 1'b0;
      o_hit_idx   <= '0;
      o_free      <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      o_free      <= handshake;
      o_proto_err <= err;
      if (capture) begin
        arrived <= arrived_nxt;
        match_q <= (match_q & ~fresh) | (i_match   & fresh);
        perm_q  <= (perm_q  & ~fresh) | (i_perm_ok & fresh);
        lock_q  <= (lock_q  & ~fresh) | (i_locked  & fresh);
        if (state == IDLE) priv_q <= i_priv_m;
      end
      if (handshake) arrived <= '0;
      if (state == RESOLVE) begin
        o_hit     <= found;
        o_hit_idx <= idx;
        o_fault   <= fault_c;
      end
    end
  end

  assign o_valid = (state == HOLD);

endmodule

// File: tb/tb_pmp_join16_resolver.sv
// Directed and randomized bench for pmp_join16_resolver against a per-entry
// scoreboard of first-captured results and a priority-rule verdict function.
module tb_pmp_join16_resolver;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] i_drive, i_match, i_perm_ok, i_locked;
  logic        i_priv_m, i_ready;
  logic        o_valid, o_fault, o_hit, o_free, o_proto_err;
  logic [3:0]  o_hit_idx;

  always #5 clk = ~clk;

  pmp_join16_resolver #(.N_ENTRY(16)) dut (
    .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_match(i_match),
    .i_perm_ok(i_perm_ok), .i_locked(i_locked), .i_priv_m(i_priv_m),
    .o_valid(o_valid), .i_ready(i_ready), .o_fault(o_fault), .o_hit(o_hit),
    .o_hit_idx(o_hit_idx), .o_free(o_free), .o_proto_err(o_proto_err)
  );

  int unsigned n_vec = 0, n_bad = 0;

  // Scoreboard: which entries have reported, and what each first reported.
  logic [15:0] m_arr, m_match, m_perm, m_lock;
  logic        m_priv;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {fault, hit, idx}: first matching entry decides; no match faults outside M-mode.
  function automatic logic [5:0] ref_verdict(input logic [15:0] m, input logic [15:0] p,
                                             input logic [15:0] l, input logic pv);
    for (int i = 0; i < 16; i++)
      if (m[i]) return {~p[i] & (~pv | l[i]), 1'b1, 4'(i)};
    return {~pv, 1'b0, 4'd0};
  endfunction

  task automatic drv(input logic [15:0] d, input logic [15:0] m, input logic [15:0] p,
                     input logic [15:0] l, input logic pm);
    logic [15:0] fresh;
    logic        exp_err;
    if (m_arr == 16'hFFFF) begin
      exp_err = |d;
      fresh   = '0;
    end else begin
      exp_err = |(d & m_arr);
      fresh   = d & ~m_arr;
      if (m_arr == '0 && fresh != '0) m_priv = pm;
      for (int i = 0; i < 16; i++)
        if (fresh[i]) begin
          m_match[i] = m[i];
          m_perm[i]  = p[i];
          m_lock[i]  = l[i];
        end
      m_arr = m_arr | fresh;
    end
    i_drive = d; i_match = m; i_perm_ok = p; i_locked = l; i_priv_m = pm;
    tick;
    i_drive = '0;
    chk("proto_err", {15'd0, o_proto_err}, {15'd0, exp_err});
    chk("free_quiet", {15'd0, o_free}, 16'd0);
  endtask

  task automatic resolve_and_check;
    logic [5:0] v;
    chk("valid_in_resolve", {15'd0, o_valid}, 16'd0);
    tick;
    chk("valid_in_hold", {15'd0, o_valid}, 16'd1);
    v = ref_verdict(m_match, m_perm, m_lock, m_priv);
    chk("fault", {15'd0, o_fault}, {15'd0, v[5]});
    chk("hit", {15'd0, o_hit}, {15'd0, v[4]});
    chk("hit_idx", {12'd0, o_hit_idx}, {12'd0, v[3:0]});
  endtask

  task automatic accept(input int unsigned w);
    logic [5:0] snap;
    snap    = {o_fault, o_hit, o_hit_idx};
    i_ready = 1'b0;
    repeat (w) begin
      tick;
      chk("valid_backpressure", {15'd0, o_valid}, 16'd1);
      chk("verdict_stable", {10'd0, o_fault, o_hit, o_hit_idx}, {10'd0, snap});
      chk("free_backpressure", {15'd0, o_free}, 16'd0);
    end
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    chk("free_pulse", {15'd0, o_free}, 16'd1);
    chk("valid_drop", {15'd0, o_valid}, 16'd0);
    chk("verdict_kept", {10'd0, o_fault, o_hit, o_hit_idx}, {10'd0, snap});
    m_arr = '0;
  endtask

  function automatic logic [15:0] rmatch;
    if ($urandom_range(3, 0) == 0) return 16'h0000;
    return 16'($urandom & $urandom & $urandom);
  endfunction

  task automatic rand_txn;
    int unsigned order[16];
    int unsigned pos;
    int unsigned k;
    int unsigned j, t;
    logic [15:0] d;
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    pos = 0;
    while (pos < 16) begin
      d = '0;
      k = $urandom_range(4, 1);
      for (int unsigned c = 0; c < k && pos < 16; c++) begin
        d[order[pos]] = 1'b1;
        pos++;
      end
      if (m_arr != '0 && $urandom_range(3, 0) == 0)
        d = d | (m_arr & (16'(1) << $urandom_range(15, 0)));
      if ($urandom_range(3, 0) == 0)
        drv('0, rmatch(), 16'($urandom), 16'($urandom), 1'($urandom));
      drv(d, rmatch(), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    resolve_and_check;
    if ($urandom_range(2, 0) == 0)
      drv(16'(1) << $urandom_range(15, 0), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    accept($urandom_range(3, 0));
  endtask

  initial begin
    rstn = 1'b0; i_drive = '0; i_match = '0; i_perm_ok = '0; i_locked = '0;
    i_priv_m = 1'b0; i_ready = 1'b0;
    m_arr = '0; m_match = '0; m_perm = '0; m_lock = '0; m_priv = 1'b0;
    tick; tick;
    chk("rst_outputs", {10'd0, o_valid, o_fault, o_hit, o_free, o_proto_err, o_hit_idx != 0}, 16'd0);
    rstn = 1'b1;
    tick;

    // All 16 in one cycle, no match, M-mode: allow.
    drv(16'hFFFF, 16'h0000, 16'($urandom), 16'($urandom), 1'b1);
    resolve_and_check;
    accept(0);

    // Reverse order, U-mode, lowest hit entry 5 lacks permission; early ready is harmless.
    i_ready = 1'b1;
    for (int k = 15; k >= 0; k--) begin
      if (k == 0) i_ready = 1'b0;
      drv(16'(1) << k, 16'h0120, 16'hFFDF, 16'($urandom), 1'b0);
    end
    resolve_and_check;
    accept(0);

    // M-mode, entry 3 no permission: unlocked allows, locked faults.
    drv(16'hFFFF, 16'h0008, 16'hFFF7, 16'h0000, 1'b1);
    resolve_and_check;
    accept(0);
    drv(16'hFFFF, 16'h0008, 16'hFFF7, 16'h0008, 1'b1);
    resolve_and_check;
    accept(5);

    // Duplicate on entry 7 keeps first data; duplicate on the completing cycle too.
    drv(16'h0080, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    drv(16'h0080, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
    drv(16'hFF7C, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    drv(16'h0007, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    resolve_and_check;
    drv(16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 1'b1);
    accept(1);

    // Dropped HOLD drive must not count toward the next transaction.
    drv(16'hFFFE, 16'h0400, 16'h0000, 16'h0000, 1'b0);
    tick;
    chk("valid_incomplete", {15'd0, o_valid}, 16'd0);
    tick;
    chk("valid_incomplete2", {15'd0, o_valid}, 16'd0);
    drv(16'h0001, 16'h0001, 16'h0001, 16'h0000, 1'b0);
    resolve_and_check;
    accept(0);

    // Reset after 9 drives discards the partial transaction.
    for (int k = 0; k < 9; k++)
      drv(16'(1) << k, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
    rstn = 1'b0;
    tick;
    chk("midrst_outputs", {10'd0, o_valid, o_fault, o_hit, o_free, o_proto_err, o_hit_idx != 0}, 16'd0);
    rstn = 1'b1;
    m_arr = '0; m_match = '0; m_perm = '0; m_lock = '0;
    tick;
    chk("postrst_free", {15'd0, o_free}, 16'd0);
    chk("postrst_valid", {15'd0, o_valid}, 16'd0);
    rand_txn();

    for (int n = 0; n < 40; n++) rand_txn();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pmp_join16_resolver.md
# pmp_join16_resolver

Synchronous 16-way join and priority resolver for the PMP check path. It sits directly downstream of the 16-way PMP splitter: the splitter drives the 16 per-entry PMP comparators, and this block consumes their per-entry results. Results may arrive in any order and in any cycle. The block waits until all 16 results are present, then selects the lowest-index matching entry per RISC-V PMP priority. It presents one allow/fault verdict to the MMU over a valid/ready handshake and pulses `o_free` back upstream to release the splitter for the next request.

## Interface
Parameters:
- `N_ENTRY`, 16: number of PMP entries joined. Fixed at 16; the index output is 4 bits wide.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `i_drive`  in  16  per-entry one-cycle result strobe; bit k marks that entry k's result is valid this cycle.
- `i_match`  in  16  entry k address match, sampled when `i_drive[k]`=1.
- `i_perm_ok`  in  16  entry k R/W/X permits the access, sampled with `i_drive[k]`.
- `i_locked`  in  16  entry k L bit, sampled with `i_drive[k]`.
- `i_priv_m`  in  1  access is M-mode; sampled on the first drive of a transaction.
- `o_valid`  out  1  verdict available.
- `i_ready`  in  1  downstream accepts the verdict.
- `o_fault`  out  1  access fault.
- `o_hit`  out  1  some entry matched.
- `o_hit_idx`  out  4  lowest matching index; 0 when `o_hit`=0.
- `o_free`  out  1  one-cycle pulse to upstream: transaction retired.
- `o_proto_err`  out  1  one-cycle pulse on protocol violation.

## Operation
Registers:
- `arrived[15:0]` bitmap;
- `match_q`, `perm_q`, `lock_q` (16 bits each);
- `priv_q`;
- state.

States:
- **IDLE**: `arrived`=0. Any `i_drive` bit causes capture, sets `arrived`, latches `i_priv_m`, and moves to COLLECT. If all 16 bits are set in that same cycle, go directly to RESOLVE.
- **COLLECT**: For each `i_drive[k]`=1 with `arrived[k]`=0, capture entry k's results and set `arrived[k]`.
  - `i_drive[k]`=1 with `arrived[k]`=1 is a duplicate: the data is ignored and `o_proto_err` pulses; other bits in the same cycle are still captured.
  - When `arrived` (after update) = 16'hFFFF, go to RESOLVE.
- **RESOLVE** (1 cycle): Priority-encode `match_q` with lowest index first, then register the outputs:
  - `o_hit` = |`match_q`; `o_hit_idx` = that index.
  - If there is a hit, `o_fault` = !`perm_q[idx]` & (!`priv_q` | `lock_q[idx]`).
  - If there is no hit, `o_fault` = !`priv_q`.
  - Go to HOLD.
- **HOLD**: `o_valid`=1, and all verdict outputs are held stable.
  - On `o_valid`&`i_ready`, clear `arrived`, assert `o_free` for the next cycle, and go to IDLE.
- Any `i_drive` bit in RESOLVE or HOLD is dropped and pulses `o_proto_err`; it does not enter the next transaction.
- `o_proto_err` and `o_free` are registered single-cycle pulses.

## Timing
- Reset (`rstn`=0 at a rising edge): state=IDLE, `arrived`=0, and all `*_q`=0. Every output is 0: `o_valid`, `o_fault`, `o_hit`, `o_hit_idx`, `o_free`, `o_proto_err`. Reset mid-transaction discards all partial results, and no `o_free` is issued.
- Latency: the edge that samples the last outstanding drive enters RESOLVE. `o_valid` rises on the following edge, i.e. 2 cycles after the last drive is sampled. With all 16 drives in one cycle, the minimum drive-to-`o_valid` latency is 2 cycles.
- `o_valid` stays high until handshake. The verdict outputs do not change while `o_valid`=1 and `i_ready`=0.
- `o_free` is high exactly in the cycle after handshake. The earliest new drive accepted is in that same cycle (state is IDLE then).
- Verdict outputs hold their last values after handshake until the next RESOLVE. Only `o_valid` deasserts.
- Drive on an already-arrived bit in the cycle the bitmap completes: the duplicate is flagged and completion still proceeds.
- `i_ready` high before `o_valid`: no effect.

## Test plan
- All 16 drives in one cycle, `i_match`=16'h0000, `i_priv_m`=1 -> `o_valid` 2 cycles later with `o_hit`=0, `o_fault`=0. With `i_ready`=1, `o_free` pulses the next cycle.
- Drives in reverse order 15..0, one per cycle; `i_match`=16'h0120; `i_perm_ok[5]`=0, `i_perm_ok[8]`=1; `i_priv_m`=0 -> `o_valid` 2 cycles after entry 0's drive with `o_hit_idx`=5, `o_fault`=1.
- M-mode with `i_match`=16'h0008, `i_perm_ok[3]`=0: with `i_locked[3]`=0 -> `o_fault`=0; repeat with `i_locked[3]`=1 -> `o_fault`=1.
- Backpressure: hold `i_ready`=0 for 5 cycles with the verdict present -> `o_valid` stays high and the outputs are stable; `o_free` pulses only after `i_ready`=1.
- Entry 7 driven twice before completion with a different `i_match` on the second drive -> `o_proto_err` pulses once and the first-captured value is used; a drive during HOLD also pulses `o_proto_err` and the next transaction still needs all 16 drives.
- `rstn`=0 after 9 of 16 drives -> all outputs 0 and no `o_free`. A fresh 16-drive transaction then completes normally.
